demux_bit_sequencer: RTL and testbench

Upstream feeder for the 1-to-8 bit demultiplexer stage. It accepts a byte over a valid/ready handshake and serialises it one bit at a time onto the demux data input, driving the matching 3-bit select so each bit lands in its own demux output position. After all 8 bits are driven it pulses `done`, and it can then accept the next byte.

---
 rtl/demux_seq_pkg.sv | 14 +
 rtl/bit_hold_timer.sv | 31 +++
 rtl/demux_bit_sequencer.sv | 97 +++++++++
 tb/tb_demux_bit_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/demux_seq_pkg.sv
// Shared types and constants for the demux bit sequencer and its hold timer.
package demux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    localparam int NUM_BITS = 8;
    localparam int SEL_W    = 3;
    localparam int HOLD_W   = 8;

endpackage

// File: rtl/bit_hold_timer.sv
// Per-bit hold counter: counts 0..HOLD_CYCLES-1 while enabled, flags the last count.
module bit_hold_timer
    import demux_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam logic [HOLD_W-1:0] LAST_CNT = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] cnt_q;

    assign last = (cnt_q == LAST_CNT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/demux_bit_sequencer.sv
// Serialises an accepted byte onto a 1-to-8 demux: one bit plus matching select per hold period.
module demux_bit_sequencer
    import demux_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       bit_strobe,
    output logic       done,
    output logic       busy
);

    localparam logic [SEL_W-1:0] FIRST_IDX = MSB_FIRST ? SEL_W'(NUM_BITS - 1) : '0;
    localparam logic [SEL_W-1:0] LAST_BIT  = SEL_W'(NUM_BITS - 1);

    state_t              state, state_next;
    logic [NUM_BITS-1:0] data_q;
    logic [SEL_W-1:0]    idx_q;
    logic [SEL_W-1:0]    idx_next;
    logic [SEL_W-1:0]    bit_cnt_q;
    logic                out_q;
    logic                hold_last;
    logic                accept;
    logic                final_bit;

    // All handshake/status outputs decode from registered state only.
    assign in_ready   = (state != DRIVE);
    assign busy       = (state == DRIVE);
    assign done       = (state == DONE);
    assign bit_strobe = busy && hold_last;
    assign accept     = in_ready && in_valid;
    assign final_bit  = (bit_cnt_q == LAST_BIT);
    assign idx_next   = MSB_FIRST ? idx_q - 1'b1 : idx_q + 1'b1;

    assign out = out_q;
    assign s0  = idx_q[2];
    assign s1  = idx_q[1];
    assign s2  = idx_q[0];

    bit_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .enable(busy),
        .last  (hold_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaulting every combinational output first prevents latch inference on unlisted paths.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = DRIVE;
            DRIVE:   if (hold_last && final_bit) state_next = DONE;
            DONE:    state_next = in_valid ? DRIVE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // out/select stay at their last driven values outside DRIVE so the demux keeps rewriting the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            idx_q     <= '0;
            bit_cnt_q <= '0;
            out_q     <= 1'b0;
        end else if (accept) begin
            data_q    <= in_data;
            idx_q     <= FIRST_IDX;
            bit_cnt_q <= '0;
            out_q     <= in_data[FIRST_IDX];
        end else if (bit_strobe && !final_bit) begin
            idx_q     <= idx_next;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            out_q     <= data_q[idx_next];
        end
    end

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// Directed bench: three sequencer variants (LSB-first H=1, MSB-first H=1, LSB-first H=3) plus demux models.
module tb_demux_bit_sequencer;

    typedef struct packed {
        logic       out;
        logic [2:0] sel;
        logic       strobe;
        logic       done;
        logic       busy;
        logic       ready;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din [3];
    logic       vin [3];
    logic       out_w [3];
    logic       s0_w [3];
    logic       s1_w [3];
    logic       s2_w [3];
    logic       strobe_w [3];
    logic       done_w [3];
    logic       busy_w [3];
    logic       ready_w [3];
    obs_t       o [3];
    logic [7:0] dmx [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_bit_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vin[0]), .in_ready(ready_w[0]),
        .out(out_w[0]), .s0(s0_w[0]), .s1(s1_w[0]), .s2(s2_w[0]),
        .bit_strobe(strobe_w[0]), .done(done_w[0]), .busy(busy_w[0])
    );

    demux_bit_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vin[1]), .in_ready(ready_w[1]),
        .out(out_w[1]), .s0(s0_w[1]), .s1(s1_w[1]), .s2(s2_w[1]),
        .bit_strobe(strobe_w[1]), .done(done_w[1]), .busy(busy_w[1])
    );

    demux_bit_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b0)) dut_h3 (
        .clk(clk), .rst_n(rst_n), .in_data(din[2]), .in_valid(vin[2]), .in_ready(ready_w[2]),
        .out(out_w[2]), .s0(s0_w[2]), .s1(s1_w[2]), .s2(s2_w[2]),
        .bit_strobe(strobe_w[2]), .done(done_w[2]), .busy(busy_w[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_obs
        assign o[g] = {out_w[g], s0_w[g], s1_w[g], s2_w[g], strobe_w[g], done_w[g], busy_w[g], ready_w[g]};
    end

    // Transparent 1-to-8 demux downstream of each sequencer.
    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            dmx[j][o[j].sel] <= o[j].out;
        end
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Offers a byte (unless already accepted), checks every DRIVE cycle, then DONE and optionally IDLE.
    task automatic run_byte(input int inst, input logic [7:0] data, input logic [7:0] next,
                            input bit chain, input bit preaccepted, input bit msb, input int hold);
        obs_t exp;
        int   idx;
        if (!preaccepted) begin
            din[inst] = data;
            vin[inst] = 1'b1;
        end
        for (int b = 0; b < 8; b++) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (b == 0 && h == 0) begin
                    if (chain) din[inst] = next;
                    else       vin[inst] = 1'b0;
                end
                idx        = msb ? 7 - b : b;
                exp.out    = data[idx];
                exp.sel    = 3'(idx);
                exp.strobe = (h == hold - 1);
                exp.done   = 1'b0;
                exp.busy   = 1'b1;
                exp.ready  = 1'b0;
                check($sformatf("drive i%0d b%0d h%0d", inst, b, h), o[inst], exp);
            end
        end
        @(negedge clk);
        exp.strobe = 1'b0;
        exp.done   = 1'b1;
        exp.busy   = 1'b0;
        exp.ready  = 1'b1;
        check($sformatf("done i%0d", inst), o[inst], exp);
        check($sformatf("demux i%0d", inst), dmx[inst], data);
        if (!chain) begin
            @(negedge clk);
            exp.done = 1'b0;
            check($sformatf("idle i%0d", inst), o[inst], exp);
        end
    endtask

    initial begin
        int done_seen;
        for (int j = 0; j < 3; j++) begin
            din[j] = 8'h00;
            vin[j] = 1'b0;
        end

        @(negedge clk);
        check("reset lsb", o[0], 8'b0_000_0001);
        check("reset msb", o[1], 8'b0_000_0001);
        check("reset h3",  o[2], 8'b0_000_0001);
        rst_n = 1'b1;
        @(negedge clk);

        run_byte(0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        run_byte(1, 8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 1);
        run_byte(2, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 3);

        // Back-to-back: valid stays high, second byte taken in the DONE cycle.
        run_byte(0, 8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0, 1);
        run_byte(0, 8'hC3, 8'h00, 1'b0, 1'b1, 1'b0, 1);

        // Reset four cycles into a byte.
        din[0] = 8'hC6;
        vin[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vin[0] = 1'b0;
        end
        check("pre-reset busy", o[0], {1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1 check("async reset", o[0], 8'b0_000_0001);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0) done_seen++;
        end
        check("no done after reset", 8'(done_seen), 8'd0);
        check("idle after reset", o[0], 8'b0_000_0001);
        run_byte(0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
